// File: rtl/loproc_pc_vec.sv
// LoPROC fetch program counter: sequential/absolute/relative redirects,
// fixed-priority vectored interrupts with nested preemption and a return stack.
// Registered outputs, one-cycle update latency; load=0 freezes all state.
module loproc_pc_vec #(
  parameter int                    ADDR_WIDTH    = 32,
  parameter int                    PC_STEP       = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR  = '0,
  parameter int                    NUM_IRQ       = 4,
  parameter logic [ADDR_WIDTH-1:0] VECTOR_STRIDE = 'h10,
  parameter int                    STACK_DEPTH   = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               load,
  input  logic [1:0]                         jump,
  input  logic [ADDR_WIDTH-1:0]              jmp_addr,
  input  logic [NUM_IRQ-1:0]                 irq_req,
  input  logic                               irq_en,
  input  logic [ADDR_WIDTH-1:0]              vector_base,
  input  logic                               irq_ret,
  output logic [ADDR_WIDTH-1:0]              next_instr_addr,
  output logic [NUM_IRQ-1:0]                 irq_ack,
  output logic                               irq_active,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   irq_level,
  output logic                               fault
);

  localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam int LVL_W = $clog2(STACK_DEPTH + 1);
  localparam int SP_W  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [1:0] JMP_SEQ = 2'd0;
  localparam logic [1:0] JMP_ABS = 2'd1;
  localparam logic [1:0] JMP_REL = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(PC_STEP);
  // Clears the low log2(PC_STEP) bits so every fetch address is step aligned.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(STEP - ADDR_WIDTH'(1));
  localparam logic [LVL_W-1:0]      LVL_MAX    = LVL_W'(STACK_DEPTH);

  // Return stack: entry i holds the state saved by nesting level i+1.
  logic [ADDR_WIDTH-1:0] stk_addr [STACK_DEPTH];
  logic [IDX_W-1:0]      stk_idx  [STACK_DEPTH];

  logic [ADDR_WIDTH-1:0] pc;
  logic [LVL_W-1:0]      level;

  logic [ADDR_WIDTH-1:0] cand_raw;
  logic [ADDR_WIDTH-1:0] cand;
  logic                  jmp_bad;

  logic                  sel_vld;
  logic [IDX_W-1:0]      sel_idx;
  logic [ADDR_WIDTH-1:0] vec_addr;

  logic [SP_W-1:0]       top_ptr;
  logic [SP_W-1:0]       push_ptr;
  logic [ADDR_WIDTH-1:0] top_addr;
  logic [IDX_W-1:0]      top_idx;

  logic                  lvl_zero;
  logic                  take_ok;
  logic                  do_pop;
  logic                  ret_bad;
  logic                  do_take;

  // Candidate fetch address for the non-interrupt path; jump=3 behaves as sequential.
  always_comb begin
    cand_raw = pc + STEP;
    jmp_bad  = 1'b0;
    case (jump)
      JMP_SEQ: cand_raw = pc + STEP;
      JMP_ABS: cand_raw = jmp_addr;
      JMP_REL: cand_raw = pc + jmp_addr;
      default: begin
        cand_raw = pc + STEP;
        jmp_bad  = 1'b1;
      end
    endcase
    cand = cand_raw & ALIGN_MASK;
  end

  // Fixed priority: the lowest-numbered active request wins.
  always_comb begin
    sel_vld = |irq_req;
    sel_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irq_req[i]) sel_idx = IDX_W'(i);
    end
  end

  assign vec_addr = vector_base + (ADDR_WIDTH'(sel_idx) * VECTOR_STRIDE);

  // Stack pointers; top_ptr is parked at 0 when empty so it never indexes past the array.
  always_comb begin
    lvl_zero = (level == '0);
    top_ptr  = lvl_zero ? '0 : SP_W'(level - LVL_W'(1));
    push_ptr = SP_W'(level);
    top_addr = stk_addr[top_ptr];
    top_idx  = stk_idx[top_ptr];
  end

  // Event decode in priority order: return, then interrupt take, then jump/sequential.
  always_comb begin
    take_ok = irq_en && sel_vld && (level < LVL_MAX) &&
              (lvl_zero || (sel_idx < top_idx));
    do_pop  = irq_ret && !lvl_zero;
    ret_bad = irq_ret && lvl_zero;
    // A return consumes the cycle; a pending request is looked at again next cycle.
    do_take = !irq_ret && take_ok;
  end

  // Program counter update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_VECTOR;
    end else if (load) begin
      if (do_pop) begin
        pc <= top_addr;
      end else if (do_take) begin
        pc <= vec_addr;
      end else begin
        pc <= cand;
      end
    end
  end

  // Nesting depth tracks pushes and pops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level <= '0;
    end else if (load) begin
      if (do_pop) begin
        level <= level - LVL_W'(1);
      end else if (do_take) begin
        level <= level + LVL_W'(1);
      end
    end
  end

  // Return stack push; the pushed cand keeps any jump issued alongside the take.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stk_addr[i] <= '0;
        stk_idx[i]  <= '0;
      end
    end else if (load && do_take) begin
      stk_addr[push_ptr] <= cand;
      stk_idx[push_ptr]  <= sel_idx;
    end
  end

  // One-cycle pulses: acknowledge of the taken source, and fault on illegal events.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_ack <= '0;
      fault   <= 1'b0;
    end else begin
      irq_ack <= '0;
      fault   <= 1'b0;
      if (load) begin
        if (ret_bad) begin
          fault <= 1'b1;
        end else if (do_take) begin
          irq_ack <= NUM_IRQ'(1) << sel_idx;
          fault   <= jmp_bad;
        end else if (!do_pop) begin
          fault <= jmp_bad;
        end
      end
    end
  end

  assign next_instr_addr = pc;
  assign irq_level       = level;
  assign irq_active      = !lvl_zero;

endmodule

// File: tb/tb_loproc_pc_vec.sv
// Directed bench for loproc_pc_vec with an expected-result queue.
// Expectations are queued when a cycle is driven, checked after the edge.
// No backpressure; every driven cycle produces exactly one checked result.
module tb_loproc_pc_vec;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [1:0]  jump;
  logic [31:0] jmp_addr;
  logic [3:0]  irq_req;
  logic        irq_en;
  logic [31:0] vector_base;
  logic        irq_ret;
  logic [31:0] next_instr_addr;
  logic [3:0]  irq_ack;
  logic        irq_active;
  logic [2:0]  irq_level;
  logic        fault;

  typedef struct {
    logic [31:0] pc;
    logic [3:0]  ack;
    logic [2:0]  lvl;
    logic        flt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   n_step = 0;

  loproc_pc_vec dut (
    .clk             (clk),
    .rst             (rst_n),
    .load            (load),
    .jump            (jump),
    .jmp_addr        (jmp_addr),
    .irq_req         (irq_req),
    .irq_en          (irq_en),
    .vector_base     (vector_base),
    .irq_ret         (irq_ret),
    .next_instr_addr (next_instr_addr),
    .irq_ack         (irq_ack),
    .irq_active      (irq_active),
    .irq_level       (irq_level),
    .fault           (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus and queue what the DUT must show after the edge.
  task automatic cyc(input logic ld, input logic [1:0] jp, input logic [31:0] ja,
                     input logic [3:0] rq, input logic rt,
                     input logic [31:0] epc, input logic [3:0] eack,
                     input logic [2:0] elvl, input logic eflt);
    exp_t e;
    @(negedge clk);
    load     = ld;
    jump     = jp;
    jmp_addr = ja;
    irq_req  = rq;
    irq_ret  = rt;
    e.pc  = epc;
    e.ack = eack;
    e.lvl = elvl;
    e.flt = eflt;
    sb.push_back(e);
  endtask

  // Monitor: pop the oldest expectation just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      n_step++;
      chk($sformatf("pc@%0d", n_step), 64'(next_instr_addr), 64'(mon_e.pc));
      chk($sformatf("ack@%0d", n_step), 64'(irq_ack), 64'(mon_e.ack));
      chk($sformatf("lvl@%0d", n_step), 64'(irq_level), 64'(mon_e.lvl));
      chk($sformatf("active@%0d", n_step), 64'(irq_active), 64'(mon_e.lvl != 3'd0));
      chk($sformatf("fault@%0d", n_step), 64'(fault), 64'(mon_e.flt));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n       = 1'b0;
    load        = 1'b0;
    jump        = 2'd0;
    jmp_addr    = '0;
    irq_req     = '0;
    irq_en      = 1'b1;
    vector_base = 32'h5000_2000;
    irq_ret     = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", 64'(next_instr_addr), 64'h0);
    chk("rst_lvl", 64'(irq_level), 64'h0);
    chk("rst_active", 64'(irq_active), 64'h0);
    chk("rst_ack", 64'(irq_ack), 64'h0);
    chk("rst_fault", 64'(fault), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Sequential run from reset.
    cyc(1, 0, 0, 4'b0000, 0, 32'h4,  0, 0, 0);
    cyc(1, 0, 0, 4'b0000, 0, 32'h8,  0, 0, 0);
    cyc(1, 0, 0, 4'b0000, 0, 32'hC,  0, 0, 0);
    cyc(1, 0, 0, 4'b0000, 0, 32'h10, 0, 0, 0);
    cyc(1, 0, 0, 4'b0000, 0, 32'h14, 0, 0, 0);
    cyc(1, 0, 0, 4'b0000, 0, 32'h18, 0, 0, 0);
    cyc(1, 0, 0, 4'b0000, 0, 32'h1C, 0, 0, 0);
    cyc(1, 0, 0, 4'b0000, 0, 32'h20, 0, 0, 0);

    // Absolute and relative jumps, negative offset and alignment.
    cyc(1, 1, 32'h400,       4'b0000, 0, 32'h400, 0, 0, 0);
    cyc(1, 0, 0,             4'b0000, 0, 32'h404, 0, 0, 0);
    cyc(1, 2, 32'hFFFF_FFF0, 4'b0000, 0, 32'h3F4, 0, 0, 0);
    cyc(1, 2, 32'h6,         4'b0000, 0, 32'h3F8, 0, 0, 0);
    cyc(1, 1, 32'h100,       4'b0000, 0, 32'h100, 0, 0, 0);

    // Single interrupt and return.
    cyc(1, 0, 0, 4'b0100, 0, 32'h5000_2020, 4'b0100, 1, 0);
    cyc(1, 0, 0, 4'b0000, 0, 32'h5000_2024, 0, 1, 0);
    cyc(1, 0, 0, 4'b0000, 1, 32'h104,       0, 0, 0);

    // Nested preemption by a higher priority source; lower priority held off.
    cyc(1, 0, 0, 4'b0100, 0, 32'h5000_2020, 4'b0100, 1, 0);
    cyc(1, 0, 0, 4'b0001, 0, 32'h5000_2000, 4'b0001, 2, 0);
    cyc(1, 0, 0, 4'b1000, 0, 32'h5000_2004, 0, 2, 0);
    cyc(1, 0, 0, 4'b1000, 0, 32'h5000_2008, 0, 2, 0);
    cyc(1, 0, 0, 4'b1000, 1, 32'h5000_2024, 0, 1, 0);
    cyc(1, 0, 0, 4'b1000, 0, 32'h5000_2028, 0, 1, 0);
    cyc(1, 0, 0, 4'b1000, 1, 32'h108,       0, 0, 0);
    cyc(1, 0, 0, 4'b1000, 0, 32'h5000_2030, 4'b1000, 1, 0);
    cyc(1, 0, 0, 4'b0000, 1, 32'h10C,       0, 0, 0);

    // Globally masked request is ignored.
    irq_en = 1'b0;
    cyc(1, 0, 0, 4'b0001, 0, 32'h110, 0, 0, 0);
    @(negedge clk);
    irq_en = 1'b1;
    sb.push_back('{32'h5000_2000, 4'b0001, 3'd1, 1'b0});
    @(negedge clk);
    irq_req = '0;
    irq_ret = 1'b1;
    sb.push_back('{32'h114, 4'b0000, 3'd0, 1'b0});

    // Nest to full depth, block the fifth take, re-nest after one return.
    cyc(1, 0, 0, 4'b1000, 0, 32'h5000_2030, 4'b1000, 1, 0);
    cyc(1, 0, 0, 4'b0100, 0, 32'h5000_2020, 4'b0100, 2, 0);
    cyc(1, 0, 0, 4'b0010, 0, 32'h5000_2010, 4'b0010, 3, 0);
    cyc(1, 0, 0, 4'b0001, 0, 32'h5000_2000, 4'b0001, 4, 0);
    cyc(1, 0, 0, 4'b0001, 0, 32'h5000_2004, 0, 4, 0);
    cyc(1, 0, 0, 4'b0001, 1, 32'h5000_2014, 0, 3, 0);
    cyc(1, 0, 0, 4'b0001, 0, 32'h5000_2000, 4'b0001, 4, 0);
    cyc(1, 0, 0, 4'b0001, 0, 32'h5000_2004, 0, 4, 0);
    cyc(1, 0, 0, 4'b0000, 1, 32'h5000_2018, 0, 3, 0);
    cyc(1, 0, 0, 4'b0000, 1, 32'h5000_2024, 0, 2, 0);
    cyc(1, 0, 0, 4'b0000, 1, 32'h5000_2034, 0, 1, 0);
    cyc(1, 0, 0, 4'b0000, 1, 32'h118,       0, 0, 0);
    cyc(1, 0, 0, 4'b0000, 1, 32'h11C,       0, 0, 1);
    cyc(1, 0, 0, 4'b0000, 0, 32'h120,       0, 0, 0);

    // Freeze with a pending request, then take it once released.
    cyc(0, 0, 0, 4'b0001, 0, 32'h120,       0, 0, 0);
    cyc(0, 1, 32'h800, 4'b0001, 1, 32'h120, 0, 0, 0);
    cyc(1, 0, 0, 4'b0001, 0, 32'h5000_2000, 4'b0001, 1, 0);
    cyc(1, 3, 0, 4'b0000, 0, 32'h5000_2004, 0, 1, 1);
    cyc(1, 0, 0, 4'b0000, 1, 32'h124,       0, 0, 0);
    cyc(1, 0, 0, 4'b0010, 0, 32'h5000_2010, 4'b0010, 1, 0);
    cyc(1, 0, 0, 4'b0001, 0, 32'h5000_2000, 4'b0001, 2, 0);

    // Asynchronous reset while nested two deep.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pc", 64'(next_instr_addr), 64'h0);
    chk("arst_lvl", 64'(irq_level), 64'h0);
    chk("arst_active", 64'(irq_active), 64'h0);
    load    = 1'b0;
    irq_req = '0;
    irq_ret = 1'b0;
    jump    = 2'd0;
    @(negedge clk);
    rst_n = 1'b1;

    // After reset the stack is empty, and sequential fetch wraps at the top of memory.
    cyc(1, 0, 0,             4'b0000, 1, 32'h4,         0, 0, 1);
    cyc(1, 1, 32'hFFFF_FFFC, 4'b0000, 0, 32'hFFFF_FFFC, 0, 0, 0);
    cyc(1, 0, 0,             4'b0000, 0, 32'h0,         0, 0, 0);
    cyc(1, 0, 0,             4'b0000, 0, 32'h4,         0, 0, 0);

    @(posedge clk);
    #2;
    chk("sb_drain", 64'(sb.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/loproc_pc_vec.md
Name: loproc_pc_vec

Overview:
Parametrised program counter for LoPROC with sequential, absolute and PC-relative jumps. Adds multi-source vectored interrupts with fixed priority and nested preemption, backed by a hardware return-address stack. Sits at the front of the fetch stage and drives next_instr_addr to instruction memory. Handles redirects from the execute stage and interrupt requests from the interrupt controller.

Parameters:
ADDR_WIDTH, 32, width of all addresses.
PC_STEP, 4, sequential increment in bytes; power of two.
RESET_VECTOR, 'h0, PC value after reset.
NUM_IRQ, 4, number of interrupt sources; index 0 has the highest priority.
VECTOR_STRIDE, 'h10, byte spacing between interrupt vectors.
STACK_DEPTH, 4, maximum interrupt nesting depth.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
load  in  1  advance enable; 0 freezes the whole block.
jump  in  2  0 sequential, 1 absolute, 2 relative, 3 reserved.
jmp_addr  in  ADDR_WIDTH  absolute target (mode 1) or signed offset (mode 2).
irq_req  in  NUM_IRQ  level-sensitive interrupt requests.
irq_en  in  1  global interrupt enable.
vector_base  in  ADDR_WIDTH  base address of the vector table.
irq_ret  in  1  return-from-interrupt strobe.
next_instr_addr  out  ADDR_WIDTH  current fetch address (registered).
irq_ack  out  NUM_IRQ  one-hot, one-cycle pulse when a source is taken.
irq_active  out  1  high when irq_level is nonzero.
irq_level  out  $clog2(STACK_DEPTH+1)  current nesting depth.
fault  out  1  one-cycle pulse on an illegal event.

Behaviour:
- Reset (rst=0, asynchronous) sets:
  - next_instr_addr=RESET_VECTOR
  - irq_level=0
  - stack cleared
  - irq_ack=0, fault=0
- All state updates on the rising clk edge. irq_ack and fault are registered outputs and default to 0 every cycle.
- load=0: PC, stack and level hold. All inputs are ignored; irq_req stays pending because it is level-sensitive. irq_ack=0, fault=0.
- load=1, priority order in the same cycle: irq_ret, then interrupt take, then jump/sequential.
- Candidate address (cand), computed every cycle:
  - jump=0: PC+PC_STEP.
  - jump=1: jmp_addr.
  - jump=2: PC+jmp_addr. Two's complement arithmetic, wraps modulo 2^ADDR_WIDTH.
  - jump=3: PC+PC_STEP and fault pulses.
  - The low log2(PC_STEP) bits of cand are forced to 0.
- irq_ret with irq_level>0:
  - PC <= top entry address; pop; level decrements.
  - Any jump in the same cycle is discarded.
  - An interrupt is not taken in the same cycle; it is re-evaluated the next cycle (tail-chaining).
- irq_ret with irq_level=0: no pop; PC <= cand; fault pulses.
- Interrupt take requires all of:
  - irq_en=1.
  - irq_req nonzero.
  - Selected index k (lowest set bit) is strictly lower than the index stored in the top entry, or irq_level=0.
  - irq_level<STACK_DEPTH.
- On take:
  - Push {cand, k}; level increments.
  - PC <= vector_base + k*VECTOR_STRIDE (wraps).
  - irq_ack[k] pulses the next cycle.
  - The jump's effect is preserved through the pushed cand.
- Request that fails the take conditions (masked, equal or lower priority, or stack full): not taken, no fault, stays pending.
- Each stack entry holds the return address (ADDR_WIDTH bits) plus the source index ($clog2(NUM_IRQ) bits).
- Sequential wrap: PC=2^ADDR_WIDTH-PC_STEP goes to 0.
- Reset asserted mid-nesting clears the stack immediately.

Test Plan:
All scenarios use default parameters, vector_base='h5000_2000, irq_en=1 unless stated.
1. Reset then load=1 for 5 cycles -> next_instr_addr 0,4,8,'hC,'h10,'h14. irq_level=0, fault=0.
2. At PC='h20, jump=1 with jmp_addr='h400 -> 'h400 then 'h404. At PC='h404, jump=2 with jmp_addr='hFFFF_FFF0 -> 'h3F4. jump=2 with jmp_addr='h6 -> target low bits forced to 0.
3. At PC='h100, irq_req=4'b0100 -> PC='h5000_2020, irq_ack=4'b0100, irq_level=1, stack top {'h104,2}. Then irq_ret -> PC='h104, irq_level=0.
4. Inside IRQ2, raise irq_req[0] -> PC='h5000_2000, irq_level=2. Raise irq_req[3] while level=1 with source 2 -> not taken until both returns complete, then taken.
5. Hold irq_req[0] and issue repeated irq_ret to re-nest up to 4 levels -> 5th take blocked, irq_level stays 4. irq_ret at level 0 -> fault pulses once, PC=PC+4.
6. load=0 with irq_req=1 -> PC frozen, no ack. load back to 1 -> taken next edge. jump=3 -> fault pulse, PC+4. Reset at level 2 -> PC=0, irq_level=0 asynchronously.
